// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types, opcodes and funct3 widths for the load/store unit
package rv32i_types;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3 encodings selecting access width and load extension
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_HOLD = 2'd2
  } lsu_state_t;

  // Operand and bookkeeping fields handed over by the scoreboard
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [4:0]  fi;
    logic [4:0]  fj;
    logic [4:0]  fk;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
  } fu_status_t;

  // Queue entry: the issued op plus its effective address, fixed at enqueue
  typedef struct packed {
    fu_status_t  status;
    logic [31:0] addr;
  } lsq_entry_t;

  // Finished-op record, carrying the retirement-trace memory fields
  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        misaligned;
  } fu_complete_t;

  // Half-words need an even address, words a 4-byte aligned one
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      LS_H, LS_HU: mis = addr_lo[0];
      LS_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-lane masks, store data shift and load extraction/extension
module lsu_data_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  lane_mask,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt      = {addr_lo, 3'b000};
  assign rshift     = rdata >> shamt;
  assign lane_wdata = store_data << shamt;

  // Lane mask by access width; shifted masks simply lose lanes past byte 3
  always_comb begin
    lane_mask = 4'b0000;
    case (funct3)
      LS_B, LS_BU: lane_mask = 4'b0001 << addr_lo;
      LS_H, LS_HU: lane_mask = 4'b0011 << addr_lo;
      LS_W:        lane_mask = 4'b1111;
      default:     lane_mask = 4'b0000;
    endcase
  end

  // Move the addressed bytes to bit 0, then sign- or zero-extend
  always_comb begin
    load_data = rshift;
    case (funct3)
      LS_B:    load_data = {{24{rshift[7]}}, rshift[7:0]};
      LS_H:    load_data = {{16{rshift[15]}}, rshift[15:0]};
      LS_BU:   load_data = {24'h000000, rshift[7:0]};
      LS_HU:   load_data = {16'h0000, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

endmodule

// File: rtl/lsu_queued.sv
// rtl/lsu_queued.sv - queued in-order load/store unit; LSU_MISALIGN_TRAP_EN makes misaligned ops bypass memory
module lsu_queued
  import rv32i_types::*;
#(
  parameter int DEPTH = 4  // power of two, at least 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  fu_status_t   issue_data,
  output logic         complete_valid,
  input  logic         complete_ready,
  output fu_complete_t complete_data,
  output logic [31:0]  dmem_addr,
  output logic [3:0]   dmem_rmask,
  output logic [3:0]   dmem_wmask,
  output logic [31:0]  dmem_wdata,
  input  logic [31:0]  dmem_rdata,
  input  logic         dmem_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  lsq_entry_t       queue [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  lsu_state_t   state;
  lsu_state_t   state_next;
  lsq_entry_t   cur;
  lsq_entry_t   in_entry;
  lsq_entry_t   head;
  fu_complete_t resp_rec;

  logic        kill;
  logic        issue_fire;
  logic        start;
  logic        enq;
  logic        deq;
  logic        head_trap;
  logic        cur_store;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic        unused_bits;

  assign kill        = rst | flush;
  assign issue_ready = (count != FULL);
  assign issue_fire  = issue_valid & issue_ready & ~kill;

  assign in_entry.status = issue_data;
  assign in_entry.addr   = issue_data.vj + issue_data.imm;

  // With an empty queue the incoming op is the head, so it can start the same cycle
  assign head  = (count != '0) ? queue[rd_ptr] : in_entry;
  assign start = (state == LSU_IDLE) & ~complete_valid & ~kill & ((count != '0) | issue_fire);
  assign deq   = start & (count != '0);
  assign enq   = issue_fire & ~(start & (count == '0));

`ifdef LSU_MISALIGN_TRAP_EN
  assign head_trap = is_misaligned(head.status.funct3, head.addr[1:0]);
`else
  assign head_trap = 1'b0;
`endif

  assign cur_store   = (cur.status.opcode == OP_STORE);
  assign unused_bits = ^{cur.status.vj, cur.status.imm};

  lsu_data_align u_align (
    .funct3     (cur.status.funct3),
    .addr_lo    (cur.addr[1:0]),
    .store_data (cur.status.vk),
    .rdata      (dmem_rdata),
    .lane_mask  (lane_mask),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  // Circular op queue; flush and reset drop every entry
  always_ff @(posedge clk) begin
    if (kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        queue[wr_ptr] <= in_entry;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
    end
  end

  // Capture the head op as the in-flight op when it leaves IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
    end else if (start) begin
      cur <= head;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (kill) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: one memory request at a time, result held until taken
  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: begin
        if (start) begin
          state_next = head_trap ? LSU_HOLD : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (dmem_resp) begin
          state_next = LSU_HOLD;
        end
      end
      LSU_HOLD: begin
        if (complete_valid && complete_ready) begin
          state_next = LSU_IDLE;
        end
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  // Memory port is only driven while a request is in flight
  always_comb begin
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    if (state == LSU_REQ) begin
      dmem_addr = {cur.addr[31:2], 2'b00};
      if (cur_store) begin
        dmem_wmask = lane_mask;
        dmem_wdata = lane_wdata;
      end else begin
        dmem_rmask = lane_mask;
      end
    end
  end

  // Completion record for the in-flight op, formed from the current response
  always_comb begin
    resp_rec          = '0;
    resp_rec.order    = cur.status.order;
    resp_rec.inst     = cur.status.inst;
    resp_rec.rs1_addr = cur.status.fj;
    resp_rec.rs2_addr = cur.status.fk;
    resp_rec.pc_rdata = cur.status.pc;
    resp_rec.pc_wdata = cur.status.pc + 32'd4;
    resp_rec.mem_addr = cur.addr;
    if (cur_store) begin
      resp_rec.mem_wmask = lane_mask;
      resp_rec.mem_wdata = lane_wdata;
    end else begin
      resp_rec.rd        = cur.status.fi;
      resp_rec.data      = load_data;
      resp_rec.mem_rmask = lane_mask;
      resp_rec.mem_rdata = dmem_rdata;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  fu_complete_t trap_rec;

  // Misaligned ops report without touching memory: no rd, no data, no masks
  always_comb begin
    trap_rec            = '0;
    trap_rec.order      = head.status.order;
    trap_rec.inst       = head.status.inst;
    trap_rec.rs1_addr   = head.status.fj;
    trap_rec.rs2_addr   = head.status.fk;
    trap_rec.pc_rdata   = head.status.pc;
    trap_rec.pc_wdata   = head.status.pc + 32'd4;
    trap_rec.mem_addr   = head.addr;
    trap_rec.misaligned = 1'b1;
  end
`endif

  // Result register: loaded on response (or trap), released on writeback handshake
  always_ff @(posedge clk) begin
    if (kill) begin
      complete_valid <= 1'b0;
      complete_data  <= '0;
    end else if ((state == LSU_REQ) && dmem_resp) begin
      complete_valid <= 1'b1;
      complete_data  <= resp_rec;
`ifdef LSU_MISALIGN_TRAP_EN
    end else if (start && head_trap) begin
      complete_valid <= 1'b1;
      complete_data  <= trap_rec;
`endif
    end else if ((state == LSU_HOLD) && complete_valid && complete_ready) begin
      complete_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_queued.sv
// tb/tb_lsu_queued.sv - directed vector bench for lsu_queued
module tb_lsu_queued;
  import rv32i_types::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         issue_valid;
  logic         issue_ready;
  fu_status_t   issue_data;
  logic         complete_valid;
  logic         complete_ready;
  fu_complete_t complete_data;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_rmask;
  logic [3:0]   dmem_wmask;
  logic [31:0]  dmem_wdata;
  logic [31:0]  dmem_rdata;
  logic         dmem_resp;

  always #5 clk = ~clk;

  lsu_queued #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_data     (issue_data),
    .complete_valid (complete_valid),
    .complete_ready (complete_ready),
    .complete_data  (complete_data),
    .dmem_addr      (dmem_addr),
    .dmem_rmask     (dmem_rmask),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic fu_status_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [31:0] vj, input logic [31:0] vk,
                                    input logic [31:0] imm, input logic [4:0] fi,
                                    input logic [31:0] pc, input logic [63:0] ord);
    fu_status_t s;
    s        = '0;
    s.opcode = opc;
    s.funct3 = f3;
    s.vj     = vj;
    s.vk     = vk;
    s.imm    = imm;
    s.fi     = fi;
    s.fj     = 5'd1;
    s.fk     = 5'd2;
    s.pc     = pc;
    s.inst   = {25'h0, opc};
    s.order  = ord;
    return s;
  endfunction

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [4:0]  fi;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_rmask;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_maddr;
    logic [31:0] e_pcw;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    // opc, f3, vj, vk, imm, fi, pc, rdata | addr, rmask, wmask, wdata, rd, data, mem_addr, pc_wdata
    vecs[0] = '{OP_STORE, LS_W, 32'h100, 32'hDEADBEEF, 32'h4, 5'd5, 32'h1000, 32'h0,
                32'h104, 4'b0000, 4'b1111, 32'hDEADBEEF, 5'd0, 32'h0, 32'h104, 32'h1004};
    vecs[1] = '{OP_LOAD, LS_B, 32'h200, 32'h0, 32'h3, 5'd7, 32'h1004, 32'h80AABBCC,
                32'h200, 4'b1000, 4'b0000, 32'h0, 5'd7, 32'hFFFFFF80, 32'h203, 32'h1008};
    vecs[2] = '{OP_LOAD, LS_HU, 32'h210, 32'h0, 32'hFFFFFFF2, 5'd9, 32'h1008, 32'h80AABBCC,
                32'h200, 4'b1100, 4'b0000, 32'h0, 5'd9, 32'h000080AA, 32'h202, 32'h100C};
    vecs[3] = '{OP_STORE, LS_B, 32'h301, 32'h12345678, 32'h0, 5'd3, 32'h2000, 32'h0,
                32'h300, 4'b0000, 4'b0010, 32'h34567800, 5'd0, 32'h0, 32'h301, 32'h2004};
    vecs[4] = '{OP_STORE, LS_H, 32'h400, 32'h0000BEEF, 32'h2, 5'd4, 32'h2004, 32'h0,
                32'h400, 4'b0000, 4'b1100, 32'hBEEF0000, 5'd0, 32'h0, 32'h402, 32'h2008};
    vecs[5] = '{OP_LOAD, LS_W, 32'h500, 32'h0, 32'h0, 5'd10, 32'hFFFFFFFC, 32'h11223344,
                32'h500, 4'b1111, 4'b0000, 32'h0, 5'd10, 32'h11223344, 32'h500, 32'h0};
    vecs[6] = '{OP_LOAD, LS_H, 32'h600, 32'h0, 32'h0, 5'd11, 32'h3000, 32'h0000F00D,
                32'h600, 4'b0011, 4'b0000, 32'h0, 5'd11, 32'hFFFFF00D, 32'h600, 32'h3004};
    vecs[7] = '{OP_LOAD, LS_BU, 32'h700, 32'h0, 32'h1, 5'd12, 32'h3004, 32'h0000F00D,
                32'h700, 4'b0010, 4'b0000, 32'h0, 5'd12, 32'h000000F0, 32'h701, 32'h3008};
    vecs[8] = '{OP_LOAD, LS_H, 32'h800, 32'h0, 32'h3, 5'd13, 32'h3008, 32'hAB000000,
                32'h800, 4'b1000, 4'b0000, 32'h0, 5'd13, 32'h000000AB, 32'h803, 32'h300C};
    vecs[9] = '{OP_LOAD, LS_B, 32'hFFFFFFFF, 32'h0, 32'h5, 5'd14, 32'h300C, 32'h000000FE,
                32'h4, 4'b0001, 4'b0000, 32'h0, 5'd14, 32'hFFFFFFFE, 32'h4, 32'h3010};

    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_data = '0;
    complete_ready = 1'b0; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst issue_ready", issue_ready, 1);
    chk("rst complete_valid", complete_valid, 0);
    chk("rst dmem_addr", dmem_addr, 0);
    chk("rst rmask", dmem_rmask, 0);
    chk("rst wmask", dmem_wmask, 0);
    chk("rst wdata", dmem_wdata, 0);
    chk("rst cdata zero", complete_data == '0, 1);

    // Single ops into an idle unit: masks one cycle after issue, result one after that
    for (int i = 0; i < NV; i++) begin
      issue_data  = mk(vecs[i].opc, vecs[i].f3, vecs[i].vj, vecs[i].vk, vecs[i].imm,
                       vecs[i].fi, vecs[i].pc, 64'(i + 1));
      issue_valid = 1'b1;
      chk($sformatf("v%0d ready", i), issue_ready, 1);
      @(negedge clk);
      issue_valid = 1'b0;
      chk($sformatf("v%0d dmem_addr", i), dmem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d rmask", i), dmem_rmask, vecs[i].e_rmask);
      chk($sformatf("v%0d wmask", i), dmem_wmask, vecs[i].e_wmask);
      chk($sformatf("v%0d wdata", i), dmem_wdata, vecs[i].e_wdata);
      dmem_rdata = vecs[i].rdata;
      dmem_resp  = 1'b1;
      @(negedge clk);
      dmem_resp = 1'b0;
      chk($sformatf("v%0d cvalid", i), complete_valid, 1);
      chk($sformatf("v%0d rd", i), complete_data.rd, vecs[i].e_rd);
      chk($sformatf("v%0d data", i), complete_data.data, vecs[i].e_data);
      chk($sformatf("v%0d mem_addr", i), complete_data.mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d pc_wdata", i), complete_data.pc_wdata, vecs[i].e_pcw);
      chk($sformatf("v%0d mem_rmask", i), complete_data.mem_rmask, vecs[i].e_rmask);
      chk($sformatf("v%0d mem_wmask", i), complete_data.mem_wmask, vecs[i].e_wmask);
      chk($sformatf("v%0d order", i), complete_data.order, 64'(i + 1));
      chk($sformatf("v%0d misaligned", i), complete_data.misaligned, 0);
      chk($sformatf("v%0d hold masks", i), {dmem_rmask, dmem_wmask}, 0);
      complete_ready = 1'b1;
      @(negedge clk);
      complete_ready = 1'b0;
      chk($sformatf("v%0d cvalid clr", i), complete_valid, 0);
    end

    // Full queue: five back-to-back issues with no memory response
    for (int k = 0; k < 5; k++) begin
      issue_data  = mk(OP_LOAD, LS_W, 32'h1000 + 32'(16 * k), 32'h0, 32'h0, 5'(k + 1),
                       32'h5000, 64'(20 + k));
      issue_valid = 1'b1;
      chk($sformatf("fq ready %0d", k), issue_ready, 1);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    chk("fq ready low", issue_ready, 0);
    chk("fq count", dut.count, 4);
    issue_data  = mk(OP_LOAD, LS_W, 32'h9000, 32'h0, 32'h0, 5'd30, 32'h5000, 64'd99);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fq addr %0d", k), dmem_addr, 32'h1000 + 32'(16 * k));
      chk($sformatf("fq rmask %0d", k), dmem_rmask, 4'b1111);
      dmem_rdata = 32'hC0DE0000 + 32'(k);
      dmem_resp  = 1'b1;
      @(negedge clk);
      dmem_resp = 1'b0;
      chk($sformatf("fq cvalid %0d", k), complete_valid, 1);
      chk($sformatf("fq order %0d", k), complete_data.order, 64'(20 + k));
      chk($sformatf("fq data %0d", k), complete_data.data, 32'hC0DE0000 + 32'(k));
      complete_ready = 1'b1;
      @(negedge clk);
      complete_ready = 1'b0;
      chk($sformatf("fq idle %0d", k), dmem_rmask, 0);
      @(negedge clk);
    end
    chk("fq no extra", {complete_valid, dmem_rmask}, 0);

    // Backpressure: result held while writeback stalls, next op waits
    issue_data  = mk(OP_STORE, LS_W, 32'h2000, 32'h55, 32'h0, 5'd8, 32'h6000, 64'd40);
    issue_valid = 1'b1;
    @(negedge clk);
    issue_data  = mk(OP_LOAD, LS_W, 32'h3000, 32'h0, 32'h0, 5'd6, 32'h6004, 64'd41);
    @(negedge clk);
    issue_valid = 1'b0;
    chk("bp wmask A", dmem_wmask, 4'b1111);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp cvalid %0d", c), complete_valid, 1);
      chk($sformatf("bp order %0d", c), complete_data.order, 64'd40);
      chk($sformatf("bp no req %0d", c), {dmem_rmask, dmem_wmask}, 0);
      @(negedge clk);
    end
    complete_ready = 1'b1;
    chk("bp still held", complete_data.order, 64'd40);
    @(negedge clk);
    complete_ready = 1'b0;
    chk("bp released", complete_valid, 0);
    chk("bp idle masks", dmem_rmask, 0);
    @(negedge clk);
    chk("bp B rmask", dmem_rmask, 4'b1111);
    chk("bp B addr", dmem_addr, 32'h3000);
    dmem_rdata = 32'h77;
    dmem_resp  = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("bp B order", complete_data.order, 64'd41);
    chk("bp B data", complete_data.data, 32'h77);
    complete_ready = 1'b1;
    @(negedge clk);
    complete_ready = 1'b0;

    // Flush during a request with two ops queued, plus a same-cycle issue and response
    for (int k = 0; k < 3; k++) begin
      issue_data  = mk(OP_LOAD, LS_W, 32'h4000 + 32'(4 * k), 32'h0, 32'h0, 5'd9,
                       32'h7000, 64'(50 + k));
      issue_valid = 1'b1;
      @(negedge clk);
    end
    chk("fl count pre", dut.count, 2);
    chk("fl rmask pre", dmem_rmask, 4'b1111);
    issue_data  = mk(OP_LOAD, LS_W, 32'h4100, 32'h0, 32'h0, 5'd9, 32'h7000, 64'd60);
    issue_valid = 1'b1;
    dmem_resp   = 1'b1;
    flush       = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    issue_valid = 1'b0;
    dmem_resp   = 1'b0;
    chk("fl rmask", dmem_rmask, 0);
    chk("fl count", dut.count, 0);
    chk("fl cvalid", complete_valid, 0);
    chk("fl ready", issue_ready, 1);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("fl late resp", complete_valid, 0);
    chk("fl late masks", dmem_rmask, 0);
    @(negedge clk);
    chk("fl quiet", {complete_valid, dmem_rmask}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
